cs_bist_driver: RTL and testbench
=================================

// Module: cs_bist_driver
// PURPOSE
//  Self-test source/sink for the CS window filter. Drives the CS sample input X from an
//  8-bit LFSR, skips the CS window-fill latency, then compresses N_PAT CS outputs Y into
//  a 10-bit MISR. It raises done, and pass when the signature equals GOLDEN_SIG.
//  Sits beside CS in the chip top so the filter runs at speed without a file-driven bench.
// PARAMETERS
//  N_PAT       2000    number of Y samples compressed per run (>=1)
//  LAT         9       clock edges after the start edge that are skipped before the first Y capture
//  SEED        8'hA5   LFSR seed; value 0 is illegal and is replaced by 8'h01
//  GOLDEN_SIG  10'h000 expected final MISR signature
//  CNT_W       16      width of the edge and sample counters; must hold LAT+N_PAT
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high
//  start       in   1      level sampled on clk; starts a run from IDLE or DONE
//  X           out  8      sample to CS.X, registered
//  Y           in   10     CS.Y
//  busy        out  1      high in FILL/RUN
//  done        out  1      high in DONE; held until the next start or reset
//  pass        out  1      valid while done; 1 = signature == GOLDEN_SIG
//  signature   out  10     current MISR value
//  sample_cnt  out  CNT_W  number of Y samples compressed so far
// BEHAVIOUR
//  Reset (async, immediate, including mid-run):
//   - state=IDLE, lfsr=SEED, X=0, misr=0, edge counter=0, sample_cnt=0.
//   - busy=0, done=0, pass=0.
//  LFSR (Galois, x^8+x^4+x^3+x^2+1, period 255):
//   - nxt = {l[6:0],1'b0} ^ (l[7] ? 8'h1D : 8'h00).
//  MISR (x^10+x^3+1):
//   - nxt = ({m[8:0],1'b0} ^ (m[9] ? 10'h009 : 10'h000)) ^ Y.
//  FSM IDLE -> FILL -> RUN -> DONE:
//   - IDLE: X=0. If start=1 at an edge (edge 0):
//     - X<=lfsr, lfsr<=nxt, misr<=0, sample_cnt<=0, edge counter<=0.
//     - busy<=1, done<=0, pass<=0; go to FILL.
//   - FILL: every edge X<=lfsr, lfsr<=nxt, edge counter++.
//     - Y ignored on edges 1..LAT.
//     - At edge LAT, go to RUN.
//   - RUN: X/LFSR keep stepping every edge.
//     - Edges LAT+1 .. LAT+N_PAT each do misr<=nxt(Y) and sample_cnt++.
//     - At edge LAT+N_PAT (same edge as the last capture), go to DONE.
//     - In that same edge: busy<=0, done<=1, pass<=(misr_next==GOLDEN_SIG).
//   - DONE: X, signature, pass and sample_cnt held. start=1 restarts exactly as from IDLE.
//  Rules:
//   - start is ignored while busy; it is level-sensitive, not edge-detected.
//   - A start held high through DONE restarts on the first DONE edge.
//   - X changes only on rising clk.
//   - signature is always the live misr register.
//   - Counters never wrap in a legal configuration (CNT_W sized by the user).
// TESTING
//  1 Reset, start=0 for 20 cycles -> X=00, busy=0, done=0, pass=0, signature=000.
//  2 Pulse start, SEED=A5 -> X after edges 0,1,2,3 = A5,57,AE,41; busy=1 from edge 0.
//  3 N_PAT=4, LAT=9, Y=000, GOLDEN_SIG=000 -> done=1 and pass=1 after edge 13, sample_cnt=4.
//  4 N_PAT=2, Y=001 held -> signature 001 then 003; pass=0 with GOLDEN_SIG=000.
//  5 start pulsed mid-RUN -> no effect. start in DONE -> done=0 and X=A5 after that edge.
//  6 reset asserted mid-RUN, between edges -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/cs_bist_driver.sv
// cs_bist_driver: LFSR stimulus source and MISR response compactor for at-speed self-test of the CS window filter.
module cs_bist_driver #(
  parameter int             N_PAT      = 2000,
  parameter int             LAT        = 9,
  parameter logic [7:0]     SEED       = 8'hA5,
  parameter logic [9:0]     GOLDEN_SIG = 10'h000,
  parameter int             CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       X,
  input  logic [9:0]       Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [9:0]       signature,
  output logic [CNT_W-1:0] sample_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] NPAT_C = CNT_W'(N_PAT);
  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d, x_q, x_d;
  logic [9:0]       misr_q, misr_d;
  logic [CNT_W-1:0] edge_q, edge_d, smp_q, smp_d;
  logic             pass_q, pass_d;
  logic [7:0]       lfsr_step;
  logic [9:0]       misr_step;
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] l);
    return {l[6:0], 1'b0} ^ (l[7] ? 8'h1D : 8'h00);
  endfunction
  assign lfsr_step = lfsr_nxt(lfsr_q);
  assign misr_step = ({misr_q[8:0], 1'b0} ^ (misr_q[9] ? 10'h009 : 10'h000)) ^ Y;
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    x_d     = x_q;
    misr_d  = misr_q;
    edge_d  = edge_q;
    smp_d   = smp_q;
    pass_d  = pass_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      // a run always replays the same pattern, so restart from the seed
      x_d     = SEED_EFF;
      lfsr_d  = lfsr_nxt(SEED_EFF);
      misr_d  = '0;
      edge_d  = '0;
      smp_d   = '0;
      pass_d  = 1'b0;
      state_d = (LAT == 0) ? RUN : FILL;
    end else if (state_q == FILL || state_q == RUN) begin
      x_d    = lfsr_q;
      lfsr_d = lfsr_step;
      edge_d = edge_q + 1'b1;
      if (state_q == FILL) begin
        state_d = (edge_d == LAT_C) ? RUN : FILL;
      end else begin
        misr_d = misr_step;
        smp_d  = smp_q + 1'b1;
        if (smp_d == NPAT_C) begin
          state_d = DONE;
          pass_d  = (misr_step == GOLDEN_SIG);
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      x_q     <= '0;
      misr_q  <= '0;
      edge_q  <= '0;
      smp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      misr_q  <= misr_d;
      edge_q  <= edge_d;
      smp_q   <= smp_d;
      pass_q  <= pass_d;
    end
  end
  assign X          = x_q;
  assign busy       = (state_q == FILL) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign signature  = misr_q;
  assign sample_cnt = smp_q;
endmodule

// File: tb/tb_cs_bist_driver.sv
// tb_cs_bist_driver: scoreboard bench for cs_bist_driver with a short N_PAT run.
module tb_cs_bist_driver;
  localparam int N = 4;
  localparam int L = 9;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  X;
  logic [9:0]  Y;
  logic        busy, done, pass;
  logic [9:0]  signature;
  logic [15:0] sample_cnt;
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_x_q[$];
  logic [9:0]  exp_sig_q[$];
  int          exp_cnt_q[$];
  cs_bist_driver #(.N_PAT(N), .LAT(L), .SEED(8'hA5), .GOLDEN_SIG(10'h000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .sample_cnt(sample_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] lnx(input logic [7:0] l);
    return {l[6:0], 1'b0} ^ (l[7] ? 8'h1D : 8'h00);
  endfunction
  function automatic logic [9:0] mnx(input logic [9:0] m, input logic [9:0] y);
    return ({m[8:0], 1'b0} ^ (m[9] ? 10'h009 : 10'h000)) ^ y;
  endfunction
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; Y = 10'h000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (X !== 8'h00) begin errors++; $display("FAIL reset_x got %h exp 00", X); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
    checks++; if (signature !== 10'h000) begin errors++; $display("FAIL reset_sig got %h exp 000", signature); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt); end
  endtask
  // mode 0: Y held at yv; mode 1: random Y each edge. start pulsed again after edge pulse_k.
  task automatic test_run(input int mode, input logic [9:0] yv, input int pulse_k);
    logic [7:0] l, xe;
    logic [9:0] m, yc, se;
    int sc, ce;
    l = 8'hA5; m = '0; sc = 0;
    start = 1'b1; Y = yv;
    for (int k = 0; k <= L + N; k++) begin
      yc = Y;
      exp_x_q.push_back(l);
      l = lnx(l);
      if (k > L) begin m = mnx(m, yc); sc++; end
      exp_sig_q.push_back(m);
      exp_cnt_q.push_back(sc);
      @(posedge clk);
      @(negedge clk);
      start = (k == pulse_k);
      Y = mode ? 10'($urandom) : yv;
      xe = exp_x_q.pop_front(); se = exp_sig_q.pop_front(); ce = exp_cnt_q.pop_front();
      checks++; if (X !== xe) begin errors++; $display("FAIL x edge%0d got %h exp %h", k, X, xe); end
      checks++; if (signature !== se) begin errors++; $display("FAIL sig edge%0d got %h exp %h", k, signature, se); end
      checks++; if (sample_cnt !== 16'(ce)) begin errors++; $display("FAIL cnt edge%0d got %0d exp %0d", k, sample_cnt, ce); end
      checks++; if (busy !== (k < L + N)) begin errors++; $display("FAIL busy edge%0d got %b exp %b", k, busy, k < L + N); end
      checks++; if (done !== (k == L + N)) begin errors++; $display("FAIL done edge%0d got %b exp %b", k, done, k == L + N); end
    end
    start = 1'b0;
    checks++; if (pass !== (m == 10'h000)) begin errors++; $display("FAIL pass got %b exp %b", pass, m == 10'h000); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1", done); end
    checks++; if (signature !== m) begin errors++; $display("FAIL sig_hold got %h exp %h", signature, m); end
  endtask
  task automatic test_restart();
    Y = 10'h155;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (X !== 8'hA5) begin errors++; $display("FAIL restart_x got %h exp a5", X); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b exp 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
    checks++; if (signature !== 10'h000) begin errors++; $display("FAIL restart_sig got %h exp 000", signature); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt got %0d exp 0", sample_cnt); end
  endtask
  task automatic test_reset_midrun();
    repeat (11) @(negedge clk);
    checks++; if (sample_cnt !== 16'd2) begin errors++; $display("FAIL midrun_cnt got %0d exp 2", sample_cnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (X !== 8'h00) begin errors++; $display("FAIL arst_x got %h exp 00", X); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b exp 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL arst_pass got %b exp 0", pass); end
    checks++; if (signature !== 10'h000) begin errors++; $display("FAIL arst_sig got %h exp 000", signature); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", sample_cnt); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_run(0, 10'h000, -1);
    test_run(0, 10'h001, 11);
    test_restart();
    test_reset_midrun();
    test_run(1, 10'($urandom), 10);
    test_run(0, 10'h000, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
